// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB round-robin arbiter: FSM state encoding
// and default sizing constants.
package apb_arb_pkg;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_AW          = 8;
  localparam int DEF_DW          = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward (with wrap) starting
// one above last_gnt and returns the first requesting index as one-hot.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int LGW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LGW-1:0]  last_gnt,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [LGW-1:0] w_idx;

  // Walk the requesters in priority order after the last grant; first hit wins
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = LGW'((int'(last_gnt) + k) % NREQ);
      if (!valid && req[w_idx]) begin
        winner[w_idx] = 1'b1;
        valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// APB master shared by NREQ requesters with round-robin arbitration.
// Optional feature: define APB_ARB_TIMEOUT_EN to terminate an ACCESS phase
// that sees no pready for TIMEOUT_CYC edges (done with err=1, rdata=0).
//
// Requester handshake: a requester holds req[i] (with its wr/addr/wdata
// stable) until it sees done[i] for one cycle. gnt[i] is high from the
// cycle the transfer enters SETUP until the completion edge. Fields are
// latched at the arbitration edge, so they may change after gnt appears.
// Dropping req mid-transfer does not cancel the transfer.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AW-1:0]     paddr,
  output logic [DW-1:0]     pwdata,
  input  logic              pready,
  input  logic [DW-1:0]     prdata,
  output logic [1:0]        dbg_state
);

  localparam int LGW = $clog2(NREQ);

  state_t          r_state;
  logic [LGW-1:0]  r_last_gnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [DW-1:0]   r_rdata;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;

  logic [NREQ-1:0] w_arb_req;
  logic [NREQ-1:0] w_winner;
  logic            w_valid;
  logic [LGW-1:0]  w_win_idx;
  logic            w_timeout;
  logic            w_complete;
  logic            w_launch;

  // The owner is masked out during ACCESS so completion hands off to someone else
  assign w_arb_req = (r_state == ACCESS) ? (req & ~r_gnt) : req;

  rr_arbiter #(
    .NREQ (NREQ),
    .LGW  (LGW)
  ) u_rr_arbiter (
    .req      (w_arb_req),
    .last_gnt (r_last_gnt),
    .winner   (w_winner),
    .valid    (w_valid)
  );

  // Convert the one-hot winner into an index for field selection
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner[i]) w_win_idx = LGW'(i);
    end
  end

  assign w_complete = (r_state == ACCESS) && (pready || w_timeout);
  assign w_launch   = w_valid && ((r_state == IDLE) || w_complete);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  assign w_timeout = (r_state == ACCESS) && !pready &&
                     (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  // Count stalled ACCESS edges; zero outside ACCESS so every SETUP starts fresh
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if ((r_state != ACCESS) || w_complete) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // APB phase sequencing, round-robin hand-off and response capture
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= LGW'(NREQ - 1);
      r_gnt      <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (w_complete) begin
            r_done    <= r_gnt;
            r_rdata   <= (r_pwrite || w_timeout) ? '0 : prdata;
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A launch overrides the IDLE/return-to-IDLE values above
      if (w_launch) begin
        r_state    <= SETUP;
        r_gnt      <= w_winner;
        r_last_gnt <= w_win_idx;
        r_psel     <= 1'b1;
        r_penable  <= 1'b0;
        r_pwrite   <= req_wr[w_win_idx];
        r_paddr    <= req_addr[w_win_idx*AW +: AW];
        r_pwdata   <= req_wr[w_win_idx] ? req_wdata[w_win_idx*DW +: DW] : '0;
      end
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios followed by randomized rounds.
// Expected grant order comes from a round-robin model over the request mask.
module tb_apb_arbiter;

  localparam int NREQ        = 4;
  localparam int AW          = 8;
  localparam int DW          = 8;
  localparam int TIMEOUT_CYC = 16;

  // ---------------- clock / reset / signals ----------------
  logic              pclk = 1'b0;
  logic              prst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_wr = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic              pready = 1'b0;
  logic [DW-1:0]     prdata = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [1:0]        dbg_state;

  always #5 pclk = ~pclk;

  apb_arbiter #(
    .NREQ        (NREQ),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .pclk      (pclk),
    .prst_n    (prst_n),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_last;            // requester served most recently
  logic [2:0] exp_q[$];          // expected service order for a round

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_gnt"}, gnt, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_psel"}, psel, 0);
    chk({pfx, "_penable"}, penable, 0);
    chk({pfx, "_pwrite"}, pwrite, 0);
    chk({pfx, "_paddr"}, paddr, 0);
    chk({pfx, "_pwdata"}, pwdata, 0);
    chk({pfx, "_rdata"}, rdata, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_state"}, dbg_state, 0);
  endtask

  task automatic apply_reset();
    prst_n = 1'b0;
    req    = '0;
    pready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    prst_n = 1'b1;
    m_last = NREQ - 1;
  endtask

  // One APB transfer for the expected owner.
  // drop: 0 keep req, 1 drop req once SETUP is seen, 2 scramble fields then drop at done.
  task automatic do_xfer(input int owner, input int waits, input logic [DW-1:0] rd,
                         input int drop, input bit from_idle, input bit more);
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    int            lat;
    bit            seen;
    exp_wr   = req_wr[owner];
    exp_addr = req_addr[owner*AW +: AW];
    exp_wd   = exp_wr ? req_wdata[owner*DW +: DW] : '0;
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 20; c++) begin
      if (psel === 1'b1 && penable === 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    chk("setup_seen", seen, 1);
    if (!seen) return;
    chk("setup_latency", lat, from_idle ? 1 : 0);
    chk("setup_gnt", gnt, 64'(1) << owner);
    chk("setup_pwrite", pwrite, exp_wr);
    chk("setup_paddr", paddr, exp_addr);
    chk("setup_pwdata", pwdata, exp_wd);
    if (drop == 1) req[owner] = 1'b0;
    if (drop == 2) begin
      req_wr[owner]               = 1'($urandom);
      req_addr[owner*AW +: AW]    = AW'($urandom);
      req_wdata[owner*DW +: DW]   = DW'($urandom);
    end
    pready = 1'b0;
    tick();
    chk("access_psel_penable", {psel, penable}, 2'b11);
    chk("access_gnt", gnt, 64'(1) << owner);
    chk("access_done_low", done, 0);
    for (int j = 0; j < waits; j++) begin
      tick();
      chk("wait_penable", penable, 1);
      chk("wait_paddr", paddr, exp_addr);
      chk("wait_pwrite", pwrite, exp_wr);
      chk("wait_pwdata", pwdata, exp_wd);
      chk("wait_done_low", done, 0);
    end
    pready = 1'b1;
    prdata = rd;
    tick();
    pready = 1'b0;
    prdata = DW'($urandom);
    chk("done_owner", done, 64'(1) << owner);
    chk("done_rdata", rdata, exp_wr ? '0 : rd);
    chk("done_err", err, 0);
    chk("done_psel", psel, more);
    if (!more) chk("done_gnt_clear", gnt, 0);
    if (drop == 2) req[owner] = 1'b0;
    m_last = owner;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [NREQ-1:0] mask;
    bit              first;
    bit              any_done;
    logic [2:0]      o;

    tick();
    apply_reset();

    // Single write from requester 0, owner drops req mid-transfer
    req_wr[0]             = 1'b1;
    req_addr[0*AW +: AW]  = 8'h10;
    req_wdata[0*DW +: DW] = 8'hA5;
    req                   = 4'b0001;
    do_xfer(0, 0, 8'h00, 1, 1'b1, 1'b0);
    tick();
    chk("single_done_pulse", done, 0);
    chk("single_idle_psel", psel, 0);

    // Read with three wait states from requester 2
    req_wr[2]             = 1'b0;
    req_addr[2*AW +: AW]  = 8'h3C;
    req_wdata[2*DW +: DW] = 8'h77;
    req                   = 4'b0100;
    do_xfer(2, 3, 8'h5A, 2, 1'b1, 1'b0);
    tick();

    // Contention: all four held high, order 0,1,2,3,0 from reset
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_wr[i]             = 1'($urandom);
      req_addr[i*AW +: AW]  = AW'($urandom);
      req_wdata[i*DW +: DW] = DW'($urandom);
    end
    req   = 4'b1111;
    first = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_xfer(k % NREQ, 0, DW'($urandom), 0, first, 1'b1);
      first = 1'b0;
    end
    // Next transfer (owner 1) is in SETUP; let it reach ACCESS then reset
    req    = '0;
    pready = 1'b0;
    tick();
    chk("pre_reset_penable", penable, 1);
    chk("pre_reset_gnt", gnt, 4'b0010);
    prst_n = 1'b0;
    tick();
    check_all_zero("abort");
    prst_n = 1'b1;
    m_last = NREQ - 1;
    tick();
    chk("abort_no_done", done, 0);
    chk("abort_idle", psel, 0);

    // Stalled slave: requester 1 read, pready never rises
    req_wr[1]            = 1'b0;
    req_addr[1*AW +: AW] = 8'hC3;
    prdata               = 8'hFF;
    req                  = 4'b0010;
    tick();
    chk("stall_setup_gnt", gnt, 4'b0010);
    chk("stall_setup_psel", psel, 1);
    req = '0;
    tick();
    chk("stall_access", penable, 1);
`ifdef APB_ARB_TIMEOUT_EN
    for (int j = 1; j <= TIMEOUT_CYC; j++) begin
      tick();
      if (j < TIMEOUT_CYC) begin
        chk("to_early_done", done, 0);
        chk("to_early_err", err, 0);
      end else begin
        chk("to_done", done, 4'b0010);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 0);
      end
    end
    m_last = 1;
    tick();
    chk("to_err_pulse", err, 0);
    chk("to_idle", psel, 0);
`else
    any_done = 1'b0;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (done !== '0) any_done = 1'b1;
    end
    chk("stall_no_done", any_done, 0);
    chk("stall_psel", psel, 1);
    chk("stall_penable", penable, 1);
    chk("stall_err", err, 0);
    apply_reset();
`endif

    // Random rounds: each requester in the mask is served once, in cyclic order
    for (int r = 0; r < 30; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        req_wr[i]             = 1'($urandom);
        req_addr[i*AW +: AW]  = AW'($urandom);
        req_wdata[i*DW +: DW] = DW'($urandom);
      end
      exp_q.delete();
      for (int k = 1; k <= NREQ; k++) begin
        if (mask[(m_last + k) % NREQ]) exp_q.push_back(3'((m_last + k) % NREQ));
      end
      req   = mask;
      first = 1'b1;
      while (exp_q.size() > 0) begin
        o = exp_q.pop_front();
        do_xfer(int'(o), $urandom_range(0, 3), DW'($urandom), 2, first, exp_q.size() > 0);
        first = 1'b0;
      end
      tick();
      chk("round_idle", psel, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
